// File: rtl/bank_switch.sv
// Bank-level packet switch: NPB local nodes plus one mesh port share a
// single hold register, round-robin arbitrated, routed by (x,y,z) address.
package bank_pkg;
    localparam int NODES_PER_BANK = 4;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] z;
    } addr_t;

    typedef struct packed {
        logic [3:0]  ctrl;
        addr_t       addr;
        logic [31:0] data;
    } pkt_t;
endpackage

module bank_switch
    import bank_pkg::*;
#(
    parameter int X_ID = 0,
    parameter int Y_ID = 0,
    parameter int NPB  = NODES_PER_BANK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPB-1:0]   src_valid,
    output logic [NPB-1:0]   src_ready,
    input  pkt_t [NPB-1:0]   src_pkt,
    input  logic             mesh_in_valid,
    output logic             mesh_in_ready,
    input  pkt_t             mesh_in_pkt,
    output logic [NPB-1:0]   dst_valid,
    input  logic [NPB-1:0]   dst_ready,
    output pkt_t             dst_pkt,
    output logic             mesh_out_valid,
    input  logic             mesh_out_ready,
    output pkt_t             mesh_out_pkt,
    output logic [15:0]      drop_count
);
    localparam int NS = NPB + 1;
    localparam int PW = $clog2(NS);

    typedef enum logic {
        S_EMPTY,
        S_FULL
    } state_t;

    state_t          r_state;
    state_t          w_next;
    pkt_t            r_hold;
    pkt_t            w_win_pkt;
    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   w_win;
    logic [15:0]     r_drop_count;
    logic [NS-1:0]   w_req;
    logic            w_found;
    logic            w_local;
    logic            w_z_ok;
    logic            w_drain;
    logic            w_drop;
    logic            w_accept;

    assign w_req = {mesh_in_valid, src_valid};
    assign w_local = (r_hold.addr.x == 4'(X_ID)) && (r_hold.addr.y == 4'(Y_ID));
    assign w_z_ok = 32'(r_hold.addr.z) < NPB;

    // Output side: only the registered hold drives any valid.
    always_comb begin
        dst_valid      = '0;
        dst_pkt        = '0;
        mesh_out_valid = 1'b0;
        mesh_out_pkt   = '0;
        w_drain        = 1'b0;
        w_drop         = 1'b0;
        if (r_state == S_FULL) begin
            if (!w_local) begin
                mesh_out_valid = 1'b1;
                mesh_out_pkt   = r_hold;
                w_drain        = mesh_out_ready;
            end else if (w_z_ok) begin
                dst_pkt = r_hold;
                for (int i = 0; i < NPB; i++) begin
                    if (32'(r_hold.addr.z) == i) begin
                        dst_valid[i] = 1'b1;
                        w_drain      = dst_ready[i];
                    end
                end
            end else begin
                w_drain = 1'b1;
                w_drop  = 1'b1;
            end
        end
    end

    // Round-robin search starting one past the last winner.
    always_comb begin
        logic [PW-1:0] idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = '0;
        for (int k = 1; k <= NS; k++) begin
            idx = PW'((int'(r_rr_ptr) + k) % NS);
            if (!w_found && w_req[idx]) begin
                w_found = 1'b1;
                w_win   = idx;
            end
        end
    end

    assign w_accept = rst && w_found && ((r_state == S_EMPTY) || w_drain);

    always_comb begin
        src_ready     = '0;
        w_win_pkt     = mesh_in_pkt;
        mesh_in_ready = w_accept && (w_win == PW'(NPB));
        for (int i = 0; i < NPB; i++) begin
            if (w_win == PW'(i)) begin
                src_ready[i] = w_accept;
                w_win_pkt    = src_pkt[i];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_accept) begin
            w_next = S_FULL;
        end else if (w_drain) begin
            w_next = S_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold       <= '0;
            r_rr_ptr     <= PW'(NPB);
            r_drop_count <= '0;
        end else begin
            if (w_accept) begin
                r_hold   <= w_win_pkt;
                r_rr_ptr <= w_win;
            end
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_bank_switch.sv
// Scoreboard bench for bank_switch: directed packets, expected deliveries
// and grants queued by the driver, checked by a negedge monitor.
module tb_bank_switch;
    import bank_pkg::*;

    localparam int NPB = 4;
    localparam int NS  = NPB + 1;

    typedef struct {
        int   port;
        pkt_t pkt;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NPB-1:0]  src_valid;
    logic [NPB-1:0]  src_ready;
    pkt_t [NPB-1:0]  src_pkt;
    logic            mesh_in_valid;
    logic            mesh_in_ready;
    pkt_t            mesh_in_pkt;
    logic [NPB-1:0]  dst_valid;
    logic [NPB-1:0]  dst_ready;
    pkt_t            dst_pkt;
    logic            mesh_out_valid;
    logic            mesh_out_ready;
    pkt_t            mesh_out_pkt;
    logic [15:0]     drop_count;

    exp_t sbq[$];
    int   gq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bank_switch #(.X_ID(1), .Y_ID(2), .NPB(NPB)) dut (
        .clk            (clk),
        .rst            (rst),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .src_pkt        (src_pkt),
        .mesh_in_valid  (mesh_in_valid),
        .mesh_in_ready  (mesh_in_ready),
        .mesh_in_pkt    (mesh_in_pkt),
        .dst_valid      (dst_valid),
        .dst_ready      (dst_ready),
        .dst_pkt        (dst_pkt),
        .mesh_out_valid (mesh_out_valid),
        .mesh_out_ready (mesh_out_ready),
        .mesh_out_pkt   (mesh_out_pkt),
        .drop_count     (drop_count)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic pkt_t mk(input logic [3:0] c, input logic [3:0] x,
                                input logic [3:0] y, input logic [3:0] z,
                                input logic [31:0] d);
        pkt_t p;
        p.ctrl   = c;
        p.addr.x = x;
        p.addr.y = y;
        p.addr.z = z;
        p.data   = d;
        return p;
    endfunction

    function automatic int idx_of(input logic [NS-1:0] v);
        for (int i = 0; i < NS; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic deliver(input int port, input pkt_t p);
        exp_t e;
        if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_delivery: port %0d pkt %h, none expected",
                     port, p);
        end else begin
            e = sbq.pop_front();
            chk("deliver_port", 64'(port), 64'(e.port));
            chk("deliver_pkt", 64'(p), 64'(e.pkt));
        end
    endtask

    always @(negedge clk) begin : mon
        logic [NS-1:0] rdy;
        logic [NS-1:0] vld;
        int            gi;
        if (rst === 1'b1) begin
            rdy = {mesh_in_ready, src_ready};
            vld = {mesh_in_valid, src_valid};
            if (rdy != '0) begin
                chk("ready_onehot", 64'($onehot(rdy)), 64'd1);
                chk("ready_to_valid", 64'(rdy & ~vld), 64'd0);
                if (gq.size() > 0) begin
                    gi = gq.pop_front();
                    chk("grant_order", 64'(idx_of(rdy)), 64'(gi));
                end
            end
            if (dst_valid != '0) begin
                chk("dst_onehot", 64'($onehot(dst_valid)), 64'd1);
            end
            for (int i = 0; i < NPB; i++) begin
                if (dst_valid[i] && dst_ready[i]) deliver(i, dst_pkt);
            end
            if (mesh_out_valid && mesh_out_ready) deliver(NPB, mesh_out_pkt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pkt_t p;
        pkt_t q;
        pkt_t a;
        pkt_t b;
        pkt_t pk[NS];
        int   ord[8];
        rst            = 1'b0;
        src_valid      = '0;
        src_pkt        = '0;
        mesh_in_valid  = 1'b0;
        mesh_in_pkt    = '0;
        dst_ready      = '0;
        mesh_out_ready = 1'b0;

        // Reset state with every source offering
        repeat (2) @(posedge clk);
        #1;
        src_valid     = 4'hF;
        mesh_in_valid = 1'b1;
        #1;
        chk("rst_src_ready", 64'(src_ready), 64'd0);
        chk("rst_mesh_in_ready", 64'(mesh_in_ready), 64'd0);
        chk("rst_dst_valid", 64'(dst_valid), 64'd0);
        chk("rst_mesh_out_valid", 64'(mesh_out_valid), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        src_valid     = '0;
        mesh_in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // Single local packet, node 2 -> (1,2,3)
        dst_ready      = 4'hF;
        mesh_out_ready = 1'b1;
        p = mk(4'h5, 4'd1, 4'd2, 4'd3, 32'hCAFE0034);
        sbq.push_back('{port: 3, pkt: p});
        gq.push_back(2);
        src_pkt[2]   = p;
        src_valid[2] = 1'b1;
        @(negedge clk);
        chk("t034_src_ready", 64'(src_ready), 64'h4);
        @(posedge clk);
        #1 src_valid = '0;
        @(negedge clk);
        chk("t034_dst_valid", 64'(dst_valid), 64'h8);
        chk("t034_dst_pkt", 64'(dst_pkt), 64'(p));
        @(posedge clk);
        #1;

        // Remote packet stalled by mesh_out_ready for 5 cycles
        mesh_out_ready = 1'b0;
        p = mk(4'h1, 4'd0, 4'd0, 4'd1, 32'h00000036);
        sbq.push_back('{port: NPB, pkt: p});
        gq.push_back(0);
        src_pkt[0]   = p;
        src_valid[0] = 1'b1;
        @(negedge clk);
        chk("t036_src_ready0", 64'(src_ready), 64'h1);
        @(posedge clk);
        #1;
        src_valid[0] = 1'b0;
        q = mk(4'h2, 4'd1, 4'd2, 4'd0, 32'h11110036);
        src_pkt[1]   = q;
        src_valid[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t036_hold_valid", 64'(mesh_out_valid), 64'd1);
            chk("t036_hold_pkt", 64'(mesh_out_pkt), 64'(p));
            chk("t036_backpressure", 64'(src_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        mesh_out_ready = 1'b1;
        sbq.push_back('{port: 0, pkt: q});
        gq.push_back(1);
        @(negedge clk);
        chk("t036_drain_accept", 64'(src_ready), 64'h2);
        @(posedge clk);
        #1 src_valid = '0;
        @(negedge clk);
        chk("t036_next_dst", 64'(dst_valid), 64'h1);
        chk("t036_mesh_idle", 64'(mesh_out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Bad local z: dropped and counted
        p = mk(4'h3, 4'd1, 4'd2, 4'd6, 32'h00000037);
        gq.push_back(3);
        src_pkt[3]   = p;
        src_valid[3] = 1'b1;
        @(negedge clk);
        chk("t037_src_ready", 64'(src_ready), 64'h8);
        chk("t037_drop_before", 64'(drop_count), 64'd0);
        @(posedge clk);
        #1 src_valid = '0;
        @(negedge clk);
        chk("t037_no_dst", 64'(dst_valid), 64'd0);
        chk("t037_no_mesh", 64'(mesh_out_valid), 64'd0);
        @(negedge clk);
        chk("t037_drop_after", 64'(drop_count), 64'd1);
        chk("t037_idle_dst", 64'(dst_valid), 64'd0);
        @(posedge clk);
        #1;

        // Reset while FULL and blocked; stale packet must vanish
        dst_ready = '0;
        p = mk(4'h4, 4'd1, 4'd2, 4'd1, 32'hDEAD0038);
        gq.push_back(0);
        src_pkt[0]   = p;
        src_valid[0] = 1'b1;
        @(negedge clk);
        chk("t038_src_ready", 64'(src_ready), 64'h1);
        @(posedge clk);
        #1;
        a = mk(4'h6, 4'd1, 4'd2, 4'd2, 32'hAAAA0038);
        b = mk(4'h7, 4'd1, 4'd2, 4'd0, 32'hBBBB0038);
        src_pkt[1]    = a;
        src_pkt[3]    = b;
        src_valid     = 4'b1010;
        mesh_in_pkt   = mk(4'h8, 4'd7, 4'd7, 4'd0, 32'hCCCC0038);
        mesh_in_valid = 1'b1;
        @(negedge clk);
        chk("t038_held_dst", 64'(dst_valid), 64'h2);
        chk("t038_blocked", 64'(src_ready), 64'd0);
        #2 rst = 1'b0;
        #1;
        chk("t038_rst_dst", 64'(dst_valid), 64'd0);
        chk("t038_rst_src_ready", 64'(src_ready), 64'd0);
        chk("t038_rst_mesh_in_ready", 64'(mesh_in_ready), 64'd0);
        chk("t038_rst_mesh_out", 64'(mesh_out_valid), 64'd0);
        dst_ready = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sbq.push_back('{port: 2, pkt: a});
        #2 rst = 1'b1;
        #1;
        chk("t038_first_grant", 64'(src_ready), 64'h2);
        chk("t038_first_mesh", 64'(mesh_in_ready), 64'd0);
        chk("t038_no_stale", 64'(dst_valid), 64'd0);
        @(posedge clk);
        #1;
        src_valid     = '0;
        mesh_in_valid = 1'b0;
        @(negedge clk);
        chk("t038_deliver", 64'(dst_valid), 64'h4);
        chk("t038_deliver_pkt", 64'(dst_pkt), 64'(a));
        @(posedge clk);
        #1;

        // Continuous contention from 0,1,3 and mesh after a fresh reset
        rst = 1'b0;
        @(posedge clk);
        #1;
        pk[0] = mk(4'h9, 4'd1, 4'd2, 4'd0, 32'h35350000);
        pk[1] = mk(4'hA, 4'd1, 4'd2, 4'd1, 32'h35350001);
        pk[2] = '0;
        pk[3] = mk(4'hB, 4'd1, 4'd2, 4'd2, 32'h35350003);
        pk[4] = mk(4'hC, 4'd5, 4'd5, 4'd0, 32'h35350004);
        ord   = '{0, 1, 3, 4, 0, 1, 3, 4};
        for (int k = 0; k < 8; k++) begin
            gq.push_back(ord[k]);
            if (ord[k] == 0) sbq.push_back('{port: 0, pkt: pk[0]});
            if (ord[k] == 1) sbq.push_back('{port: 1, pkt: pk[1]});
            if (ord[k] == 3) sbq.push_back('{port: 2, pkt: pk[3]});
            if (ord[k] == 4) sbq.push_back('{port: NPB, pkt: pk[4]});
        end
        rst           = 1'b1;
        src_pkt[0]    = pk[0];
        src_pkt[1]    = pk[1];
        src_pkt[3]    = pk[3];
        mesh_in_pkt   = pk[4];
        src_valid     = 4'b1011;
        mesh_in_valid = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        src_valid     = '0;
        mesh_in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back local stream from node 2, no bubbles
        for (int k = 0; k < 6; k++) begin
            p = mk(4'(k), 4'd1, 4'd2, 4'(k % 4), 32'h00003900 + 32'(k));
            sbq.push_back('{port: k % 4, pkt: p});
            src_pkt[2]   = p;
            src_valid[2] = 1'b1;
            @(negedge clk);
            chk("t039_ready", 64'(src_ready), 64'h4);
            if (k > 0) begin
                chk("t039_no_bubble", 64'(dst_valid), 64'(1 << ((k - 1) % 4)));
            end
            @(posedge clk);
            #1;
        end
        src_valid = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        chk("grants_drained", 64'(gq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bank_switch.md
BANK_SWITCH -- requirements
Module: bank_switch

Interface
REQ-001 Parameter X_ID, default 0: mesh x coordinate of this bank.
REQ-002 Parameter Y_ID, default 0: mesh y coordinate of this bank.
REQ-003 Parameter NPB, default NODES_PER_BANK: number of local node ports.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert by system.
REQ-006 src_valid  input  NPB  per-node packet-offered flags (node valid_out).
REQ-007 src_ready  output  NPB  per-node accept (node ready_out).
REQ-008 src_pkt  input  NPB x pkt_t  per-node packets (node out_pkt).
REQ-009 mesh_in_valid / mesh_in_ready / mesh_in_pkt  input / output / pkt_t  packets arriving from the mesh.
REQ-010 dst_valid  output  NPB  per-node delivery flags (node valid_in).
REQ-011 dst_ready  input  NPB  per-node accept (node ready_in).
REQ-012 dst_pkt  output  pkt_t  shared delivery packet, meaningful only where dst_valid set.
REQ-013 mesh_out_valid / mesh_out_ready / mesh_out_pkt  output / input / pkt_t  packets leaving toward the mesh.
REQ-014 drop_count  output  16  number of packets discarded for bad local address.

Function
REQ-015 Sources indexed 0..NPB-1 (nodes) and NPB (mesh_in); a transfer occurs on a cycle where valid and ready are both high.
REQ-016 Block holds exactly one packet in a hold register; FSM states EMPTY and FULL.
REQ-017 Arbitration: round-robin over the NPB+1 sources, search starting at rr_ptr+1 modulo NPB+1, first valid source wins.
REQ-018 Ready asserted combinationally to the winning source only, when state EMPTY or hold is draining this cycle; all other readies 0.
REQ-019 rr_ptr updates to the winning index only on an accepted transfer; unchanged otherwise.
REQ-020 Hold packet is local when addr.x == X_ID and addr.y == Y_ID; otherwise remote.
REQ-021 FULL, local, addr.z < NPB: dst_valid[addr.z] = 1, other dst_valid bits 0, dst_pkt = hold; drains when dst_ready[addr.z] high.
REQ-022 FULL, remote: mesh_out_valid = 1, mesh_out_pkt = hold; drains when mesh_out_ready high.
REQ-023 FULL, local, addr.z >= NPB: packet drains unconditionally that cycle, no valid raised, drop_count increments by 1, saturating at 16'hFFFF.
REQ-024 Drain and new accept in the same cycle allowed: state stays FULL with new packet; sustained throughput 1 packet/cycle.
REQ-025 Drain without accept: FULL -> EMPTY. Accept while EMPTY: EMPTY -> FULL. Latency from accept to offered output: 1 cycle.
REQ-026 Outputs valid only from registered state; valid never withdrawn nor packet changed while FULL and not drained.
REQ-027 Packet contents (ctrl, addr, data) pass through unmodified; ctrl not inspected.
REQ-028 dst_pkt and mesh_out_pkt driven to '0 when their valids are low.
REQ-029 No source accepted while state FULL and drain blocked (backpressure propagates).

Reset
REQ-030 On rst low, immediately: state EMPTY, hold '0, rr_ptr = NPB, drop_count 0.
REQ-031 During reset all src_ready, mesh_in_ready, dst_valid, mesh_out_valid = 0.
REQ-032 Reset mid-transfer discards the held packet; no partial delivery after release.
REQ-033 After release, first grant search begins at source 0.

Verification (NPB=4, X_ID=1, Y_ID=2)
REQ-034 Node 2 offers SUM to (1,2,3), dst_ready all 1 -> src_ready[2]=1 same cycle; next cycle dst_valid=4'b1000, dst_pkt equal to input.
REQ-035 Nodes 0,1,3 and mesh_in all valid continuously, sinks ready -> grant order 0,1,3,4(mesh),0,... one per cycle.
REQ-036 Hold packet to (0,0,1), mesh_out_ready low 5 cycles -> mesh_out_valid held 5 cycles with stable packet, all src_ready 0; drains on cycle ready rises.
REQ-037 Packet to (1,2,6) -> no valid output, drop_count 0->1, state EMPTY next cycle.
REQ-038 rst driven low while FULL with dst_ready low -> outputs 0 asynchronously; after release, no stale delivery, first grant to lowest-index valid source.
REQ-039 Back-to-back local packets with dst_ready high -> accept and drain every cycle, no bubble.
